ball_motion: RTL and testbench
==============================

# ball_motion

Ball position generator for the Ball-and-Paddle game. Each movement step it advances the ball one pixel per axis, and it reflects the ball off the left, right and top walls and off the paddle. It detects misses at the bottom edge and sequences serve and respawn. Its `bx`/`by` outputs feed `heading_detect` directly and the video renderer.

## Interface
- `H_RES`, 640, playfield width in pixels
- `V_RES`, 480, playfield height in pixels
- `BALL_SIZE`, 8, ball side length in pixels (square ball)
- `PADDLE_Y`, 460, y coordinate of the paddle's top edge
- `PADDLE_W`, 64, paddle width in pixels
- `START_X`, 316, ball x after reset or respawn
- `START_Y`, 236, ball y after reset or respawn
- `STEP_DIV`, 250000, clocks per movement step (must be ≥ 2)
- `SERVE_DELAY`, 60, steps the ball stays frozen after a miss

Ports:
- `clk`  in  1  system clock
- `rst`  in  1  synchronous, active-high reset
- `serve`  in  1  launch request; level or pulse, sampled each clock
- `px`  in  11  paddle left-edge x coordinate
- `bx`  out  11  ball left-edge x coordinate (registered)
- `by`  out  11  ball top-edge y coordinate (registered)
- `in_play`  out  1  high while state is PLAY
- `bounce`  out  1  one-clock pulse on any reflection
- `miss`  out  1  one-clock pulse on entering MISS

## Operation
- Step strobe: a free-running counter counts 0..STEP_DIV-1 and wraps. `step` is high when the count equals STEP_DIV-1. All motion happens only on `step` clocks.
- Direction registers: `dx` (1 = increasing x) and `dy` (1 = increasing y, downward).
- States:
  - IDLE: ball held at (START_X, START_Y). `serve` high moves to PLAY on the next clock and sets dx=1, dy=0.
  - PLAY: on each step, compute the new directions, then move:
    - x: if dx=1 and bx==H_RES-BALL_SIZE, dx←0. If dx=0 and bx==0, dx←1. Then bx ← bx±1 using the new dx.
    - y top: if dy=0 and by==0, dy←1.
    - y paddle: if dy=1, by+BALL_SIZE==PADDLE_Y, bx+BALL_SIZE>px and bx<px+PADDLE_W, then dy←0.
    - y miss: if dy=1 and by==V_RES-BALL_SIZE, go to MISS. Position is not updated on that step; `miss` pulses.
    - Otherwise by ← by±1 using the new dy.
  - MISS: ball frozen. Count SERVE_DELAY steps, then go to IDLE with bx=START_X, by=START_Y, dx=1, dy=0.
- `bounce` pulses once on a step where any flip occurs. Simultaneous x and y flips (a corner) still give a single pulse.
- `serve` is ignored in PLAY and MISS.
- Width rules:
  - All comparisons are 11-bit unsigned.
  - `bx+BALL_SIZE` and `px+PADDLE_W` are evaluated at 12 bits, so no wrap.
  - The ball never leaves [0, H_RES-BALL_SIZE] × [0, V_RES-BALL_SIZE].

## Timing
- Reset (synchronous) gives:
  - state IDLE
  - bx=START_X, by=START_Y
  - dx=1, dy=0
  - step counter 0, delay counter 0
  - in_play=0, bounce=0, miss=0
- Reset asserted mid-PLAY or mid-MISS overrides everything on that edge.
- Step latency: `bx`/`by` change on the clock edge where `step` is high and are visible the following cycle. Every PLAY step changes each coordinate by exactly ±1. The only exception is the miss step, where nothing moves.
- IDLE→PLAY transition: one clock after `serve` is sampled high. The first movement occurs on the next `step`; the step counter is not reset.
- `bounce` and `miss` are high in the same cycle as the corresponding coordinate update (or freeze) becomes visible.
- `in_play` is registered and tracks the state with zero extra delay.
- First step after a serve moves the ball x+1, y−1. Downstream `heading_detect` must see xh=1, yh=0.

## Test plan
Common parameters: STEP_DIV=2, H_RES=64, V_RES=48, BALL_SIZE=4, PADDLE_Y=44, PADDLE_W=16, START_X=30, START_Y=20, SERVE_DELAY=3.

- Reset and serve:
  - Stimulus: hold rst for 2 clocks, check outputs, then pulse `serve`.
  - Required: after reset bx=30, by=20, in_play=0. After serve, in_play=1. After the 1st step bx=31, by=19.
- Top wall:
  - Stimulus: continue from serve with no further input.
  - Required: step 20 gives (50,0). Step 21 gives (51,1) with `bounce`=1 for exactly one clock.
- Right wall:
  - Stimulus: continue.
  - Required: step 30 gives (60,10). Step 31 gives (59,11) with `bounce`.
- Paddle hit:
  - Stimulus: px=20, continue.
  - Required: step 60 gives (30,40). Step 61 gives (29,39) with `bounce`.
- Miss and respawn:
  - Stimulus: px=0, continue.
  - Required: step 61 gives (29,41). Step 64 gives (26,44). Step 65 leaves (26,44) unchanged with `miss`=1 and in_play=0. After 3 more steps the ball is back at (30,20) in IDLE, and `serve` is accepted again.
- Reset mid-play and serve while playing:
  - Stimulus: assert `rst` at step 10, and separately hold `serve` high throughout PLAY.
  - Required: `rst` returns the block to IDLE at (30,20) on that edge with no pulses. Holding `serve` during PLAY has no effect.

Source files
------------

// File: rtl/ball_motion.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : ball_motion                                                   |
// | Purpose  : Ball position generator with wall/paddle reflection, miss     |
// |            detection and serve/respawn sequencing.                       |
// | Revision : 1.0  initial release                                          |
// +--------------------------------------------------------------------------+
module ball_motion #(
    parameter int H_RES       = 640,
    parameter int V_RES       = 480,
    parameter int BALL_SIZE   = 8,
    parameter int PADDLE_Y    = 460,
    parameter int PADDLE_W    = 64,
    parameter int START_X     = 316,
    parameter int START_Y     = 236,
    parameter int STEP_DIV    = 250000,
    parameter int SERVE_DELAY = 60
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        serve,
    input  logic [10:0] px,
    output logic [10:0] bx,
    output logic [10:0] by,
    output logic        in_play,
    output logic        bounce,
    output logic        miss
);

    localparam int c_cnt_w = $clog2(STEP_DIV);
    localparam int c_dly_w = (SERVE_DELAY > 1) ? $clog2(SERVE_DELAY) : 1;

    localparam logic [10:0]        c_x_max    = 11'(H_RES - BALL_SIZE);
    localparam logic [10:0]        c_y_max    = 11'(V_RES - BALL_SIZE);
    localparam logic [10:0]        c_start_x  = 11'(START_X);
    localparam logic [10:0]        c_start_y  = 11'(START_Y);
    localparam logic [c_cnt_w-1:0] c_cnt_last = c_cnt_w'(STEP_DIV - 1);
    localparam logic [c_dly_w-1:0] c_dly_last = c_dly_w'(SERVE_DELAY - 1);

    localparam logic [1:0] c_st_idle = 2'd0;
    localparam logic [1:0] c_st_play = 2'd1;
    localparam logic [1:0] c_st_miss = 2'd2;

    logic [1:0]         r_state, w_state_n;
    logic [10:0]        r_bx, w_bx_n;
    logic [10:0]        r_by, w_by_n;
    logic               r_dx, w_dx_n;
    logic               r_dy, w_dy_n;
    logic [c_cnt_w-1:0] r_cnt;
    logic [c_dly_w-1:0] r_dly, w_dly_n;
    logic               r_bounce, w_bounce_n;
    logic               r_miss, w_miss_n;

    logic w_step;
    logic w_flip_x;
    logic w_flip_top;
    logic w_overlap;
    logic w_flip_pad;
    logic w_at_bottom;

    assign w_step = (r_cnt == c_cnt_last);

    // Reflection conditions, evaluated on the current position/direction.
    // Sums are widened to 12 bits so that edge coordinates cannot wrap.
    assign w_flip_x    = r_dx ? (r_bx == c_x_max) : (r_bx == 11'd0);
    assign w_flip_top  = !r_dy && (r_by == 11'd0);
    assign w_overlap   = (({1'b0, r_bx} + 12'(BALL_SIZE)) > {1'b0, px}) &&
                         ({1'b0, r_bx} < ({1'b0, px} + 12'(PADDLE_W)));
    assign w_flip_pad  = r_dy && (({1'b0, r_by} + 12'(BALL_SIZE)) == 12'(PADDLE_Y)) && w_overlap;
    assign w_at_bottom = r_dy && (r_by == c_y_max) && !w_flip_pad;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state  <= c_st_idle;
            r_bx     <= c_start_x;
            r_by     <= c_start_y;
            r_dx     <= 1'b1;
            r_dy     <= 1'b0;
            r_cnt    <= '0;
            r_dly    <= '0;
            r_bounce <= 1'b0;
            r_miss   <= 1'b0;
        end else begin
            r_state  <= w_state_n;
            r_bx     <= w_bx_n;
            r_by     <= w_by_n;
            r_dx     <= w_dx_n;
            r_dy     <= w_dy_n;
            r_cnt    <= w_step ? '0 : r_cnt + c_cnt_w'(1);
            r_dly    <= w_dly_n;
            r_bounce <= w_bounce_n;
            r_miss   <= w_miss_n;
        end
    end

    always_comb begin
        w_state_n  = r_state;
        w_bx_n     = r_bx;
        w_by_n     = r_by;
        w_dx_n     = r_dx;
        w_dy_n     = r_dy;
        w_dly_n    = r_dly;
        w_bounce_n = 1'b0;
        w_miss_n   = 1'b0;
        case (r_state)
            c_st_idle: begin
                w_bx_n = c_start_x;
                w_by_n = c_start_y;
                w_dx_n = 1'b1;
                w_dy_n = 1'b0;
                if (serve) begin
                    w_state_n = c_st_play;
                end
            end
            c_st_play: begin
                if (w_step) begin
                    // A miss freezes the ball entirely, including any pending x flip.
                    if (w_at_bottom) begin
                        w_state_n = c_st_miss;
                        w_dly_n   = '0;
                        w_miss_n  = 1'b1;
                    end else begin
                        w_dx_n     = r_dx ^ w_flip_x;
                        w_dy_n     = r_dy ^ (w_flip_top | w_flip_pad);
                        w_bx_n     = w_dx_n ? r_bx + 11'd1 : r_bx - 11'd1;
                        w_by_n     = w_dy_n ? r_by + 11'd1 : r_by - 11'd1;
                        w_bounce_n = w_flip_x | w_flip_top | w_flip_pad;
                    end
                end
            end
            c_st_miss: begin
                if (w_step) begin
                    if (r_dly == c_dly_last) begin
                        w_state_n = c_st_idle;
                        w_bx_n    = c_start_x;
                        w_by_n    = c_start_y;
                        w_dx_n    = 1'b1;
                        w_dy_n    = 1'b0;
                        w_dly_n   = '0;
                    end else begin
                        w_dly_n = r_dly + c_dly_w'(1);
                    end
                end
            end
            default: begin
                w_state_n = c_st_idle;
            end
        endcase
    end

    assign bx      = r_bx;
    assign by      = r_by;
    assign in_play = (r_state == c_st_play);
    assign bounce  = r_bounce;
    assign miss    = r_miss;

endmodule
`default_nettype wire

// File: tb/tb_ball_motion.sv
`default_nettype none
`timescale 1ns/1ps
// +--------------------------------------------------------------------------+
// | Module   : tb_ball_motion                                                |
// | Purpose  : Scoreboard bench for ball_motion against a reflection model.  |
// | Revision : 1.0  initial release                                          |
// +--------------------------------------------------------------------------+
module tb_ball_motion;

    localparam int H_RES = 64, V_RES = 48, BS = 4, PY = 44, PW = 16;
    localparam int SX = 30, SY = 20, DIV = 2, SD = 3;
    localparam int XMAX = H_RES - BS, YMAX = V_RES - BS;

    logic        clk = 1'b0;
    logic        rst, serve;
    logic [10:0] px, bx, by;
    logic        in_play, bounce, miss;

    ball_motion #(
        .H_RES(H_RES), .V_RES(V_RES), .BALL_SIZE(BS), .PADDLE_Y(PY), .PADDLE_W(PW),
        .START_X(SX), .START_Y(SY), .STEP_DIV(DIV), .SERVE_DELAY(SD)
    ) dut (
        .clk(clk), .rst(rst), .serve(serve), .px(px),
        .bx(bx), .by(by), .in_play(in_play), .bounce(bounce), .miss(miss)
    );

    always #5 clk = ~clk;

    typedef struct {
        int x;
        int y;
        bit ip;
        bit bn;
        bit ms;
    } exp_t;

    exp_t sb[$];
    int   n_checks = 0;
    int   n_fail   = 0;

    // Model: mode 0 idle, 1 play, 2 miss; velocities are +1/-1 per step.
    int m_mode, m_x, m_y, m_vx, m_vy, m_phase, m_wait, m_steps;

    task automatic model_edge(input bit r, input bit s, input int p);
        bit   is_step, bn, ms;
        exp_t e;
        is_step = (m_phase == DIV - 1);
        bn = 1'b0;
        ms = 1'b0;
        if (r) begin
            m_mode = 0; m_x = SX; m_y = SY; m_vx = 1; m_vy = -1;
            m_phase = 0; m_wait = 0; m_steps = 0;
        end else begin
            m_phase = (m_phase + 1) % DIV;
            if (m_mode == 0) begin
                if (s) begin
                    m_mode = 1;
                    m_steps = 0;
                end
            end else if (is_step) begin
                m_steps++;
                if (m_mode == 1) begin
                    if (m_x + m_vx < 0 || m_x + m_vx > XMAX) begin
                        m_vx = -m_vx;
                        bn = 1'b1;
                    end
                    if (m_y + m_vy < 0) begin
                        m_vy = 1;
                        bn = 1'b1;
                    end else if (m_vy > 0 && m_y + BS == PY && m_x + BS > p && m_x < p + PW) begin
                        m_vy = -1;
                        bn = 1'b1;
                    end else if (m_y + m_vy > YMAX) begin
                        ms = 1'b1;
                        bn = 1'b0;
                        m_mode = 2;
                        m_wait = 0;
                    end
                    if (!ms) begin
                        m_x += m_vx;
                        m_y += m_vy;
                    end
                end else begin
                    m_wait++;
                    if (m_wait == SD) begin
                        m_mode = 0; m_x = SX; m_y = SY; m_vx = 1; m_vy = -1;
                    end
                end
            end
        end
        e.x = m_x; e.y = m_y; e.ip = (m_mode == 1); e.bn = bn; e.ms = ms;
        sb.push_back(e);
    endtask

    initial begin
        forever begin
            @(posedge clk);
            model_edge(rst, serve, int'(px));
        end
    end

    initial begin
        exp_t e;
        @(posedge clk);
        forever begin
            @(negedge clk);
            n_checks++;
            if (sb.size() == 0) begin
                n_fail++;
                $display("FAIL scoreboard_empty at %0t", $time);
            end else begin
                e = sb.pop_front();
                if (bx !== 11'(e.x) || by !== 11'(e.y) || in_play !== e.ip ||
                    bounce !== e.bn || miss !== e.ms) begin
                    n_fail++;
                    $display("FAIL scoreboard at %0t: got bx=%0d by=%0d in_play=%0b bounce=%0b miss=%0b, expected bx=%0d by=%0d in_play=%0b bounce=%0b miss=%0b",
                             $time, bx, by, in_play, bounce, miss, e.x, e.y, e.ip, e.bn, e.ms);
                end
            end
        end
    end

    task automatic chk(input string name, input int act, input int req);
        n_checks++;
        if (act != req) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", name, act, req);
        end
    endtask

    task automatic wait_step(input int k);
        int guard;
        guard = 0;
        while (m_steps != k && guard < 2000) begin
            @(negedge clk);
            guard++;
        end
        if (m_steps != k) begin
            n_checks++;
            n_fail++;
            $display("FAIL wait_step: reached step %0d, wanted %0d", m_steps, k);
        end
    endtask

    task automatic chk_pos(input string name, input int x, input int y);
        chk({name, "_bx"}, int'(bx), x);
        chk({name, "_by"}, int'(by), y);
    endtask

    task automatic chk_reset_state(input string name);
        chk_pos(name, SX, SY);
        chk({name, "_in_play"}, int'(in_play), 0);
        chk({name, "_bounce"}, int'(bounce), 0);
        chk({name, "_miss"}, int'(miss), 0);
    endtask

    task automatic serve_pulse();
        serve = 1'b1;
        @(negedge clk);
        serve = 1'b0;
        chk("serve_in_play", int'(in_play), 1);
    endtask

    initial begin
        rst = 1'b1;
        serve = 1'b0;
        px = 11'd20;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk_reset_state("reset");
        rst = 1'b0;
        @(negedge clk);
        serve_pulse();

        // Trajectory with paddle under the ball at step 60
        wait_step(1);  chk_pos("step1", 31, 19);
        wait_step(20); chk_pos("top_pre", 50, 0);
        wait_step(21); chk_pos("top_hit", 51, 1); chk("top_bounce", int'(bounce), 1);
        @(negedge clk); chk("top_bounce_once", int'(bounce), 0);
        wait_step(30); chk_pos("right_pre", 60, 10);
        wait_step(31); chk_pos("right_hit", 59, 11); chk("right_bounce", int'(bounce), 1);
        wait_step(60); chk_pos("pad_pre", 30, 40);
        wait_step(61); chk_pos("pad_hit", 29, 39); chk("pad_bounce", int'(bounce), 1);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk_reset_state("reset_mid_play");

        // Paddle out of the way: miss and respawn
        px = 11'd0;
        @(negedge clk);
        serve_pulse();
        wait_step(61); chk_pos("miss_pass", 29, 41);
        wait_step(64); chk_pos("miss_pre", 26, 44);
        wait_step(65); chk_pos("miss_freeze", 26, 44);
        chk("miss_pulse", int'(miss), 1);
        chk("miss_in_play", int'(in_play), 0);
        @(negedge clk); chk("miss_once", int'(miss), 0);
        wait_step(68); chk_pos("respawn", SX, SY); chk("respawn_in_play", int'(in_play), 0);
        @(negedge clk);
        serve_pulse();

        // Serve held high throughout play; reset at step 10
        serve = 1'b1;
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        wait_step(10); chk_pos("held_step10", 40, 10);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk_reset_state("reset_step10");
        wait_step(21); chk_pos("held_top", 51, 1); chk("held_bounce", int'(bounce), 1);
        wait_step(31); chk_pos("held_right", 59, 11);
        serve = 1'b0;

        // Randomized play: paddle often placed near the ball, sporadic serve/reset
        for (int i = 0; i < 3000; i++) begin
            @(negedge clk);
            rst = ($urandom_range(0, 499) == 0);
            serve = ($urandom_range(0, 15) == 0);
            if ($urandom_range(0, 1) == 0)
                px = 11'($urandom_range(0, 60));
            else
                px = (bx > 11'd12) ? bx - 11'($urandom_range(0, 12)) : 11'd0;
        end
        rst = 1'b0;
        serve = 1'b0;
        repeat (4) @(negedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
